// File: rtl/snake_pkg.sv
// Shared constants, colours, pixel record and FSM encoding for the snake
// game video path.
package snake_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COL_W-1:0] COL_WHITE = 3'b111;
    localparam logic [COL_W-1:0] COL_RED   = 3'b100;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_ARB   = 1'b1;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping, returned both one-hot and encoded.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the VGA adapter pixel write port between several drawers and runs
// the full-screen clear sweep; drives a registered plot/x/y/colour stream.
module pixel_write_arbiter #(
    parameter int         NUM_REQ      = 3,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*7-1:0] req_y,
    input  logic [NUM_REQ*3-1:0] req_colour,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 plot,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 oob_drop
);
    import snake_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [0:0]         state;
    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic               last_col;
    logic               last_row;
    logic               sel_oob;
    pixel_t             sel;

    // Handshake: req_ready is a one-hot grant, only ever raised on a requester
    // whose req_valid is high; a pixel transfers when req_valid[i] & req_ready[i],
    // and a requester keeps x/y/colour stable while valid and not yet granted.
    always_comb begin
        arb_req = '0;
        if (state == S_ARB && !clear_start) arb_req = req_valid;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        req_ready  = grant;
        grant_any  = |grant;
        clear_busy = (state == S_CLEAR);
        sel.x      = req_x[int'(grant_idx)*X_W +: X_W];
        sel.y      = req_y[int'(grant_idx)*Y_W +: Y_W];
        sel.colour = req_colour[int'(grant_idx)*COL_W +: COL_W];
        sel_oob    = (sel.x >= X_W'(SCREEN_W)) || (sel.y >= Y_W'(SCREEN_H));
        last_col   = (cx == X_W'(SCREEN_W - 1));
        last_row   = (cy == Y_W'(SCREEN_H - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CLEAR;
            cx       <= '0;
            cy       <= '0;
            rr_ptr   <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            oob_drop <= 1'b0;
        end else begin
            plot     <= 1'b0;
            oob_drop <= 1'b0;
            if (state == S_CLEAR) begin
                // A restart request issues nothing this cycle; (0,0) goes out next.
                if (clear_start) begin
                    cx <= '0;
                    cy <= '0;
                end else begin
                    plot   <= 1'b1;
                    x      <= cx;
                    y      <= cy;
                    colour <= CLEAR_COLOUR;
                    if (last_col) begin
                        cx <= '0;
                        if (last_row) begin
                            cy    <= '0;
                            state <= S_ARB;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
            end else if (clear_start) begin
                state <= S_CLEAR;
                cx    <= '0;
                cy    <= '0;
            end else if (grant_any) begin
                rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                x        <= sel.x;
                y        <= sel.y;
                colour   <= sel.colour;
                plot     <= !sel_oob;
                oob_drop <= sel_oob;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: vector table for arbitration and
// range checks, hand sequences for clear sweeps, restarts and reset.
module tb_pixel_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  req_ready;
    logic        clear_start;
    logic        clear_busy;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        oob_drop;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [2:0] valid;
        logic       clr;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [2:0] exp_ready;
        logic       exp_plot;
        logic       exp_oob;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[15];

    pixel_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .oob_drop    (oob_drop)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [2:0] v, logic c, logic [7:0] x1, logic [6:0] y1,
                                logic [2:0] r, logic p, logic o, logic [7:0] ex,
                                logic [6:0] ey, logic [2:0] ec, logic b);
        vec_t t;
        t.valid = v; t.clr = c; t.x1 = x1; t.y1 = y1; t.exp_ready = r;
        t.exp_plot = p; t.exp_oob = o; t.ex = ex; t.ey = ey; t.ec = ec; t.exp_busy = b;
        return t;
    endfunction

    // driver: requester 0 at (10,20,001), 1 at (x1,y1,010), 2 at (50,60,100)
    task automatic drive(input logic [2:0] v, input logic c, input logic [7:0] x1, input logic [6:0] y1);
        req_valid   = v;
        clear_start = c;
        req_x       = {8'd50, x1, 8'd10};
        req_y       = {7'd60, y1, 7'd20};
        req_colour  = {3'b100, 3'b010, 3'b001};
    endtask

    // Follows a clear sweep from the current falling edge; stops when the
    // sweep ends or after stop_after plots, leaving time at that edge.
    task automatic sweep_run(input string name, input int stop_after,
                             output int busy_cnt, output int plot_cnt);
        int ex, ey, bad, rdy_bad;
        logic done;
        ex = 0; ey = 0; bad = 0; rdy_bad = 0; done = 1'b0;
        busy_cnt = 0; plot_cnt = 0;
        for (int c = 0; c < 20000; c++) begin
            if (plot === 1'b1) begin
                if (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'b000 || oob_drop !== 1'b0) bad++;
                plot_cnt++;
                ex++;
                if (ex == 160) begin ex = 0; ey++; end
            end
            if (clear_busy === 1'b1) begin
                busy_cnt++;
                if (req_ready !== 3'b000) rdy_bad++;
            end
            if (clear_busy !== 1'b1 || plot_cnt == stop_after) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_seq"}, bad, 0);
        check({name, "_ready"}, rdy_bad, 0);
    endtask

    initial begin
        int bc, pc;
        logic [17:0] got;
        reset = 1'b1;
        drive(3'b111, 1'b0, 8'd30, 7'd40);

        vecs[0]  = mk(3'b111, 0, 30, 40,  3'b001, 1, 0, 10, 20, 3'b001, 0);
        vecs[1]  = mk(3'b111, 0, 30, 40,  3'b010, 1, 0, 30, 40, 3'b010, 0);
        vecs[2]  = mk(3'b111, 0, 30, 40,  3'b100, 1, 0, 50, 60, 3'b100, 0);
        vecs[3]  = mk(3'b111, 0, 30, 40,  3'b001, 1, 0, 10, 20, 3'b001, 0);
        vecs[4]  = mk(3'b111, 0, 30, 40,  3'b010, 1, 0, 30, 40, 3'b010, 0);
        vecs[5]  = mk(3'b111, 0, 30, 40,  3'b100, 1, 0, 50, 60, 3'b100, 0);
        vecs[6]  = mk(3'b100, 0, 30, 40,  3'b100, 1, 0, 50, 60, 3'b100, 0);
        vecs[7]  = mk(3'b101, 0, 30, 40,  3'b001, 1, 0, 10, 20, 3'b001, 0);
        vecs[8]  = mk(3'b101, 0, 30, 40,  3'b100, 1, 0, 50, 60, 3'b100, 0);
        vecs[9]  = mk(3'b000, 0, 30, 40,  3'b000, 0, 0, 0, 0, 3'b000, 0);
        vecs[10] = mk(3'b010, 0, 160, 10, 3'b010, 0, 1, 0, 0, 3'b000, 0);
        vecs[11] = mk(3'b010, 0, 159, 119, 3'b010, 1, 0, 159, 119, 3'b010, 0);
        vecs[12] = mk(3'b010, 0, 5, 120,  3'b010, 0, 1, 0, 0, 3'b000, 0);
        vecs[13] = mk(3'b011, 0, 30, 40,  3'b001, 1, 0, 10, 20, 3'b001, 0);
        vecs[14] = mk(3'b001, 1, 30, 40,  3'b000, 0, 0, 0, 0, 3'b000, 1);

        // reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_plot", 32'(plot), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_colour", 32'(colour), 0);
        check("rst_oob", 32'(oob_drop), 0);
        check("rst_busy", 32'(clear_busy), 1);
        check("rst_ready", 32'(req_ready), 0);
        reset = 1'b0;

        sweep_run("sweep0", 1 << 30, bc, pc);
        check("sweep0_busy_cycles", bc, 19200);
        check("sweep0_plots", pc, 19200);

        // table: arbitration order, range checks, clear pre-emption
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].clr, vecs[i].x1, vecs[i].y1);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_plot) exp_q.push_back({vecs[i].ex, vecs[i].ey, vecs[i].ec});
            @(negedge clk);
            check($sformatf("v%0d_plot", i), 32'(plot), 32'(vecs[i].exp_plot));
            check($sformatf("v%0d_oob", i), 32'(oob_drop), 32'(vecs[i].exp_oob));
            check($sformatf("v%0d_busy", i), 32'(clear_busy), 32'(vecs[i].exp_busy));
            if (plot === 1'b1 && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check($sformatf("v%0d_pixel", i), 32'({x, y, colour}), 32'(got));
            end
        end

        // sweep after pre-emption, restarted at pixel 500
        drive(3'b001, 1'b0, 8'd30, 7'd40);
        sweep_run("preempt", 500, bc, pc);
        check("preempt_plots", pc, 500);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        check("restart_gap_plot", 32'(plot), 0);
        check("restart_busy", 32'(clear_busy), 1);
        sweep_run("restart", 1 << 30, bc, pc);
        check("restart_busy_cycles", bc, 19200);
        check("restart_plots", pc, 19200);

        // move the pointer off zero, then reset in the middle of a sweep
        drive(3'b010, 1'b0, 8'd30, 7'd40);
        #1;
        check("post_clear_ready", 32'(req_ready), 32'b010);
        @(negedge clk);
        check("post_clear_plot", 32'({plot, x, y, colour}), 32'({1'b1, 8'd30, 7'd40, 3'b010}));
        drive(3'b000, 1'b1, 8'd30, 7'd40);
        #1;
        check("clr_idle_ready", 32'(req_ready), 0);
        @(negedge clk);
        drive(3'b111, 1'b0, 8'd30, 7'd40);
        check("clr_idle_busy", 32'(clear_busy), 1);
        sweep_run("pre_reset", 3000, bc, pc);
        check("pre_reset_plots", pc, 3000);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", 32'({plot, x, y, colour, oob_drop}), 0);
        check("mid_rst_busy", 32'(clear_busy), 1);
        reset = 1'b0;
        sweep_run("post_reset", 1 << 30, bc, pc);
        check("post_reset_busy_cycles", bc, 19200);
        check("post_reset_plots", pc, 19200);
        #1;
        check("post_reset_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        check("post_reset_plot", 32'({plot, x, y, colour}), 32'({1'b1, 8'd10, 7'd20, 3'b001}));

        // report
        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single pixel write port of the 160x120 VGA adapter between several independent drawers (snake body/erase, food spawn, score overlay) and owns a full-screen clear sequencer. Each requester offers one pixel per transfer over a valid/ready handshake. The block grants requesters round-robin and drives a registered `plot`/`x`/`y`/`colour` stream into `vga_adapter`. It replaces the ad-hoc priority mux between food and snake pixels in the datapath.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters; index 0 is lowest in the initial round-robin order.
- `SCREEN_W`, 160: visible columns.
- `SCREEN_H`, 120: visible rows.
- `CLEAR_COLOUR`, 3'b000: colour written by the clear sweep.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: synchronous, active-high; one clock; all state resets on the `clk` edge where it is high.
- `req_valid` in NUM_REQ: requester i has a pixel pending.
- `req_x` in NUM_REQ*8: packed x coordinates; requester i at [8i+7:8i].
- `req_y` in NUM_REQ*7: packed y coordinates; requester i at [7i+6:7i].
- `req_colour` in NUM_REQ*3: packed colours; requester i at [3i+2:3i].
- `req_ready` out NUM_REQ: one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `clear_start` in 1: pulse; starts a full-screen clear.
- `clear_busy` out 1: high while the sweep runs.
- `plot` out 1: write enable to `vga_adapter`.
- `x` out 8: pixel column.
- `y` out 7: pixel row.
- `colour` out 3: pixel colour.
- `oob_drop` out 1: one-cycle pulse when an accepted pixel was out of range.

## Operation
- FSM has two states, S_CLEAR and S_ARB. Reset enters S_CLEAR with the sweep counters `cx=0`, `cy=0`.
- S_CLEAR behaviour:
  - Each cycle, issue pixel (cx,cy) with CLEAR_COLOUR, in row-major order: cx increments and wraps at SCREEN_W-1, then cy increments.
  - After issuing (SCREEN_W-1, SCREEN_H-1), go to S_ARB.
  - `req_ready` is all zero throughout.
- S_ARB behaviour:
  - Round-robin among asserted `req_valid`, searching upward from pointer `rr_ptr`. The reset value of `rr_ptr` is 0.
  - At most one grant per cycle.
  - After a grant to requester g, `rr_ptr` becomes (g+1) mod NUM_REQ. With no grant, `rr_ptr` holds.
- Ready rule: `req_ready` is combinational from `req_valid`, state, `rr_ptr` and `clear_start`. It is asserted only to a requester whose `req_valid` is high. A requester must hold x/y/colour stable while valid and not yet granted.
- Range check:
  - A granted pixel with x >= SCREEN_W or y >= SCREEN_H is still consumed (ready high).
  - It is not plotted: `plot=0` next cycle and `oob_drop=1` next cycle.
- `clear_start` behaviour:
  - In S_ARB it takes precedence over any request that cycle: no grant, and the FSM goes to S_CLEAR with cx=cy=0.
  - In S_CLEAR it restarts the sweep at (0,0).
- `clear_busy` = (state == S_CLEAR). It is combinational and high during the reset cycle's following state.
- Reset mid-sweep or mid-transfer:
  - Any pixel not yet registered is abandoned.
  - The sweep restarts from (0,0).
  - `rr_ptr` returns to 0.

## Timing
- Output register reset values: `plot=0`, `x=0`, `y=0`, `colour=0`, `oob_drop=0`.
- Latency: exactly 1 cycle from handshake (or sweep issue) to `plot`/`x`/`y`/`colour` valid. Throughput is 1 pixel/cycle.
- Clear sweep:
  - The first cycle after `reset` falls, `clear_busy=1`. The next cycle shows `plot=1` at (0,0).
  - The sweep issues 19200 pixels in 19200 consecutive cycles. The last plotted pixel is (159,119).
  - `clear_busy` is high for exactly 19200 cycles, and `req_ready` can be asserted on the following cycle.
- `plot` is 0 on any cycle that follows no transfer, an OOB transfer, or a `clear_start` pre-emption.

## Structure
- Shared package `snake_pkg`:
  - Constants SCREEN_W, SCREEN_H, X_W=8, Y_W=7, COL_W=3.
  - Colour constants COL_BLACK, COL_WHITE, COL_RED.
  - State encoding for S_CLEAR/S_ARB.
- Sub-module `rr_arbiter`:
  - Inputs: NUM_REQ request vector and pointer.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational.
  - The parent owns `rr_ptr`, the FSM, the sweep counters and the output registers.

## Test plan
- Reset, then idle: `clear_busy` is high for 19200 cycles. Exactly 19200 `plot` pulses occur, the first at (0,0) colour 000 and the last at (159,119). `req_ready` stays 0 until the sweep ends.
- After the clear, requesters 0, 1 and 2 hold valid continuously with distinct pixels: grants go 0,1,2,0,1,2. Each `plot` follows its handshake by 1 cycle with the matching x/y/colour.
- Only requester 2 is valid, then requesters 0 and 2 become valid: 2 is granted, then 0 (pointer=0), then 2.
- Requester 1 offers (160,10): ready=1, next cycle `plot=0` and `oob_drop=1`. Offering (159,119) plots normally.
- `clear_start` pulses while requester 0 is valid in S_ARB: no grant that cycle and `clear_busy` rises. A second `clear_start` at sweep pixel 500 restarts the sweep at (0,0).
- `reset` is asserted mid-sweep at pixel 3000: the next post-reset pixel is (0,0), the sweep again takes 19200 cycles, and the first grant goes to requester 0.
